// File: rtl/rv32i_types.sv
// rv32i_types: shared state encoding and line geometry for the pmem responder.
package rv32i_types;
   typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} pmem_state_t;
   localparam int PMEM_BURST_LEN  = 4;
   localparam int PMEM_LINE_BYTES = 32;
   localparam int PMEM_BEAT_BITS  = $clog2(PMEM_BURST_LEN);
endpackage

// File: rtl/pmem_line_ram.sv
// pmem_line_ram: 64-bit beat storage, asynchronous read port, synchronous write port.
module pmem_line_ram #(
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 i_we,
   input  logic [ADDR_BITS-1:0] i_waddr,
   input  logic [63:0]          i_wdata,
   input  logic [ADDR_BITS-1:0] i_raddr,
   output logic [63:0]          o_rdata
);
   logic [63:0] r_mem [2**ADDR_BITS];
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end
   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency 4-beat burst memory model for a cache, with sticky protocol checking.
module pmem_responder
   import rv32i_types::*;
#(
   parameter int LATENCY       = 10,
   parameter int LINE_IDX_BITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pmem_read,
   input  logic        pmem_write,
   input  logic [31:0] pmem_address,
   input  logic [63:0] pmem_wdata,
   output logic [63:0] pmem_rdata,
   output logic        pmem_resp,
   output logic        proto_err
);
   localparam int RAM_BITS = LINE_IDX_BITS + PMEM_BEAT_BITS;
   pmem_state_t               r_state, w_state_n;
   logic [7:0]                r_cnt, w_cnt_n;
   logic [PMEM_BEAT_BITS-1:0] r_beat, w_beat_n;
   logic [26:0]               r_addr, w_addr_n;
   logic                      r_write, w_write_n;
   logic                      r_err, w_err_n;
   logic                      w_viol, w_we;
   logic [RAM_BITS-1:0]       w_ram_addr;
   logic [63:0]               w_ram_rdata;
   logic                      w_unused_lsb;
   assign w_unused_lsb = ^pmem_address[4:0];
   assign w_viol = (r_write ? ~pmem_write : ~pmem_read) | (pmem_read & pmem_write)
                 | (pmem_address[31:5] != r_addr);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_beat  <= '0;
         r_addr  <= '0;
         r_write <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_beat  <= w_beat_n;
         r_addr  <= w_addr_n;
         r_write <= w_write_n;
         r_err   <= w_err_n;
      end
   end
   // The acceptance cycle itself counts toward the latency, so WAIT lasts LATENCY-1 cycles.
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_beat_n  = r_beat;
      w_addr_n  = r_addr;
      w_write_n = r_write;
      w_err_n   = r_err;
      unique case (r_state)
         IDLE: if (pmem_read | pmem_write) begin
            w_state_n = (LATENCY == 1) ? BURST : WAIT;
            w_cnt_n   = 8'(LATENCY - 1);
            w_beat_n  = '0;
            w_addr_n  = pmem_address[31:5];
            w_write_n = pmem_write & ~pmem_read;
            w_err_n   = r_err | (pmem_read & pmem_write);
         end
         WAIT: begin
            w_cnt_n   = r_cnt - 8'd1;
            w_state_n = (r_cnt == 8'd1) ? BURST : WAIT;
            w_err_n   = r_err | w_viol;
         end
         BURST: begin
            w_beat_n  = r_beat + 1'b1;
            w_state_n = (r_beat == PMEM_BEAT_BITS'(PMEM_BURST_LEN - 1)) ? DONE : BURST;
            w_err_n   = r_err | w_viol;
         end
         default: w_state_n = IDLE;
      endcase
   end
   assign pmem_resp  = (r_state == BURST);
   assign proto_err  = r_err;
   assign w_ram_addr = {r_addr[LINE_IDX_BITS-1:0], r_beat};
   // A beat in flight while reset is sampled must not land in storage.
   assign w_we       = pmem_resp & r_write & ~rst;
   assign pmem_rdata = (pmem_resp & ~r_write) ? w_ram_rdata : 64'd0;
   pmem_line_ram #(.ADDR_BITS(RAM_BITS)) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_ram_addr),
      .i_wdata (pmem_wdata),
      .i_raddr (w_ram_addr),
      .o_rdata (w_ram_rdata)
   );
endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: scoreboard bench; driver queues expected beats, monitor checks them on the falling edge.
module tb_pmem_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pmem_read = 1'b0, pmem_write = 1'b0;
   logic [31:0] pmem_address = '0;
   logic [63:0] pmem_wdata = '0;
   logic [63:0] pmem_rdata;
   logic        pmem_resp, proto_err;
   logic        rd1 = 1'b0, wr1 = 1'b0;
   logic [31:0] addr1 = '0;
   logic [63:0] wd1 = '0;
   logic [63:0] rdata1;
   logic        resp1, err1;
   int          total = 0, bad = 0, cyc = 0;
   typedef struct {int cyc; logic [63:0] data;} exp_t;
   exp_t q[$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   pmem_responder #(.LATENCY(10), .LINE_IDX_BITS(8)) u_dut (
      .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
      .pmem_resp(pmem_resp), .proto_err(proto_err));
   pmem_responder #(.LATENCY(1), .LINE_IDX_BITS(8)) u_dut1 (
      .clk(clk), .rst(rst), .pmem_read(rd1), .pmem_write(wr1),
      .pmem_address(addr1), .pmem_wdata(wd1), .pmem_rdata(rdata1),
      .pmem_resp(resp1), .proto_err(err1));
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   always @(negedge clk) begin
      if (pmem_resp) begin
         if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_beat: resp high at cycle %0d with nothing expected", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("beat_cycle", 64'(cyc), 64'(e.cyc));
            chk("beat_data", pmem_rdata, e.data);
         end
      end else if (pmem_rdata !== 64'd0) begin
         chk("idle_rdata", pmem_rdata, 64'd0);
      end
   end
   // mode 0: normal, 1: address changed mid-WAIT, 2: reset after beat 1
   task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [63:0] wd [4], input logic [63:0] rx [4], input int mode);
      int n, beats, waited, lim;
      lim = (mode == 2) ? 3 : 4;
      @(negedge clk);
      n = cyc;
      pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = '0;
      for (int k = 0; k < lim; k++) q.push_back('{n + 10 + k, rd ? rx[k] : 64'd0});
      beats = 0; waited = 0;
      while (beats < lim && waited < 40) begin
         @(negedge clk);
         waited++;
         if (mode == 1 && waited == 3) pmem_address = addr ^ 32'h0000_0100;
         if (pmem_resp) begin
            pmem_wdata = wd[beats];
            beats++;
         end
      end
      if (beats < lim) begin
         total++; bad++;
         $display("FAIL txn_timeout: got %0d beats want %0d", beats, lim);
      end
      if (mode == 2) begin
         rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0;
         @(negedge clk);
         rst = 1'b0;
         chk("abort_resp", 64'(pmem_resp), 64'd0);
      end else begin
         @(negedge clk);
         pmem_read = 1'b0; pmem_write = 1'b0;
      end
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask
   initial begin
      #400000;
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end
   initial begin
      logic [63:0] d40 [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
      logic [63:0] da  [4] = '{64'hA0A0_0000_0000_0000, 64'hA1A1_0000_0000_0001,
                               64'hA2A2_0000_0000_0002, 64'hA3A3_0000_0000_0003};
      logic [63:0] db  [4] = '{64'hB0B0_0000_0000_0000, 64'hB1B1_0000_0000_0001,
                               64'hB2B2_0000_0000_0002, 64'hB3B3_0000_0000_0003};
      logic [63:0] dmix[4] = '{64'hB0B0_0000_0000_0000, 64'hB1B1_0000_0000_0001,
                               64'hA2A2_0000_0000_0002, 64'hA3A3_0000_0000_0003};
      logic [63:0] dtop[4] = '{64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0002,
                               64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0004};
      logic [63:0] junk[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hEEEE_EEEE_EEEE_EEEE,
                               64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC};
      logic [63:0] zero[4] = '{64'd0, 64'd0, 64'd0, 64'd0};
      logic [63:0] d1  [4] = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
                               64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404};
      int ph;
      repeat (3) @(negedge clk);
      chk("rst_resp", 64'(pmem_resp), 64'd0);
      chk("rst_rdata", pmem_rdata, 64'd0);
      chk("rst_err", 64'(proto_err), 64'd0);
      rst = 1'b0;
      txn(1'b0, 1'b1, 32'h0000_0040, d40, zero, 0);
      chk("wr_err", 64'(proto_err), 64'd0);
      txn(1'b1, 1'b0, 32'h0000_0040, zero, d40, 0);
      txn(1'b1, 1'b0, 32'h0000_2040, zero, d40, 0);
      txn(1'b0, 1'b1, 32'h0000_1FE0, dtop, zero, 0);
      txn(1'b1, 1'b0, 32'hFFFF_FFE0, zero, dtop, 0);
      txn(1'b0, 1'b1, 32'h0000_0080, da, zero, 0);
      txn(1'b0, 1'b1, 32'h0000_0080, db, zero, 2);
      chk("abort_err", 64'(proto_err), 64'd0);
      txn(1'b1, 1'b0, 32'h0000_0080, zero, dmix, 0);
      chk("clean_err", 64'(proto_err), 64'd0);
      txn(1'b1, 1'b1, 32'h0000_0040, junk, d40, 0);
      chk("both_err", 64'(proto_err), 64'd1);
      txn(1'b1, 1'b0, 32'h0000_0040, zero, d40, 0);
      chk("sticky_err", 64'(proto_err), 64'd1);
      do_reset();
      chk("rereset_err", 64'(proto_err), 64'd0);
      txn(1'b1, 1'b0, 32'h0000_0040, zero, d40, 1);
      chk("addr_chg_err", 64'(proto_err), 64'd1);
      repeat (3) @(negedge clk);
      chk("queue_drained", 64'(q.size()), 64'd0);
      wr1 = 1'b1; addr1 = 32'h0000_0040;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         chk("l1_wr_resp", 64'(resp1), 64'(i <= 4));
         if (i <= 4) wd1 = d1[i-1];
      end
      wr1 = 1'b0;
      @(negedge clk);
      rd1 = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         ph = i % 6;
         chk("l1_rd_resp", 64'(resp1), 64'(ph >= 1 && ph <= 4));
         chk("l1_rd_data", rdata1, (ph >= 1 && ph <= 4) ? d1[ph-1] : 64'd0);
      end
      rd1 = 1'b0;
      chk("l1_err", 64'(err1), 64'd0);
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 Parameter LATENCY, default 10: cycles from request acceptance to the first response beat; legal range 1..255.
REQ-002 Parameter LINE_IDX_BITS, default 8: number of backing cache lines is 2^LINE_IDX_BITS, each line 32 bytes.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port pmem_read, input, 1: burst read request from the cache system.
REQ-006 Port pmem_write, input, 1: burst write request from the cache system.
REQ-007 Port pmem_address, input, 32: byte address of the line; bits [4:0] are ignored.
REQ-008 Port pmem_wdata, input, 64: write beat, consumed on each cycle pmem_resp is high during a write.
REQ-009 Port pmem_rdata, output, 64: read beat, valid on each cycle pmem_resp is high during a read.
REQ-010 Port pmem_resp, output, 1: beat strobe, high for exactly 4 consecutive cycles per transaction.
REQ-011 Port proto_err, output, 1: sticky protocol-violation flag.

Function
REQ-012 The state machine SHALL have four states: IDLE, WAIT, BURST, DONE.
REQ-013 In IDLE, a sampled pmem_read or pmem_write SHALL capture the line index (address[4+LINE_IDX_BITS:5]) and the operation, load the latency counter with LATENCY-1, and move to WAIT.
REQ-014 Address bits above the index SHALL be ignored, so the address space wraps modulo the backing size.
REQ-015 If pmem_read and pmem_write are both high in IDLE, the block SHALL treat the request as a read and set proto_err.
REQ-016 WAIT SHALL decrement the counter and move to BURST on the cycle it reads 0, so the first pmem_resp occurs exactly LATENCY cycles after acceptance.
REQ-017 BURST SHALL assert pmem_resp for beats 0..3 in consecutive cycles; beat k covers line bytes [8k+7:8k].
REQ-018 For a read, pmem_rdata SHALL equal beat k of the captured line in the same cycle pmem_resp is high (combinational read or pre-fetched, with zero added bubbles).
REQ-019 For a write, beat k of the captured line SHALL be written with pmem_wdata at the clock edge ending each resp-high cycle.
REQ-020 After beat 3, the block SHALL enter DONE for exactly one cycle with pmem_resp low, then return to IDLE; a request held high during DONE SHALL NOT be accepted.
REQ-021 pmem_rdata SHALL be 0 whenever pmem_resp is low or the transaction is a write.
REQ-022 Deassertion of the request, an opcode change, or an address change during WAIT or BURST SHALL set proto_err, and the transaction SHALL complete using the captured values.
REQ-023 proto_err SHALL stay set until reset.
REQ-024 The minimum spacing between two accepted requests SHALL be LATENCY+5 cycles.

Reset
REQ-025 On rst: state=IDLE, pmem_resp=0, pmem_rdata=0, proto_err=0, counters=0.
REQ-026 Reset asserted mid-transaction SHALL abort it with no further beats; line storage SHALL NOT be cleared, and beats already written SHALL persist.
REQ-027 Storage contents SHALL be loadable only by write transactions or by a simulation-only file preload.

Structure
REQ-028 The state enum pmem_state_t and the constants PMEM_BURST_LEN=4 and PMEM_LINE_BYTES=32 SHALL live in rv32i_types.
REQ-029 Storage SHALL be a sub-module, pmem_line_ram, with 64-bit beat width, one read port and one write port, addressed by {line_idx, beat}.
REQ-030 The top-level module pmem_responder SHALL contain only the FSM, the counters, and the capture registers.

Verification
REQ-031 With LATENCY=10: write line 0x00000040 with beats 0x11..,0x22..,0x33..,0x44.., then read it back -> pmem_resp high 4 cycles starting exactly 10 cycles after acceptance, and rdata returns the same 4 beats in order.
REQ-032 With LATENCY=1: read accepted at cycle t -> pmem_resp high at t+1..t+4, low at t+5 (DONE), and a new request is accepted at t+6.
REQ-033 Read of 0x00002040 with LINE_IDX_BITS=8 -> returns the line stored at 0x00000040 (wrap).
REQ-034 pmem_read and pmem_write both high in IDLE -> read data returned, no storage change, proto_err=1 and remaining 1 after completion.
REQ-035 rst asserted after beat 1 of a write -> pmem_resp=0 the next cycle; a later read returns new beats 0-1 and old beats 2-3.
REQ-036 Address changed mid-WAIT -> beats come from the captured line, and proto_err=1.
